// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the reduced RISC-V core front end.
//   fetch_state_t    : fetch FSM encoding (BOOT, RUN, WAIT, DROP)
//   INSTR_BYTES      : size of one instruction word in bytes
//   DEFAULT_RESET_PC : first fetch address after reset
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Groups the fetch stage's instruction-memory bus, the decode handshake and
// the branch-redirect inputs.
//   imem_req/imem_addr            : read request to instruction memory
//   imem_rvalid/imem_rdata        : read response from instruction memory
//   instr_valid/instr_ready       : valid/ready handshake toward decode
//   instr/instr_pc                : head instruction and its fetch address
//   PCsrc/branch_pc/ImmOp         : taken-branch redirect from decode
// Modports: master = fetch unit side, slave = memory/decode side.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             PCsrc;
    logic [WIDTH-1:0] branch_pc;
    logic [WIDTH-1:0] ImmOp;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rvalid, imem_rdata, instr_ready, PCsrc, branch_pc, ImmOp
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rvalid, imem_rdata, instr_ready, PCsrc, branch_pc, ImmOp
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO of {instruction, fetch address}. Entry 0 is always the head.
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_instr,
//   push_pc             : enqueue one entry
//   pop                 : dequeue the head (ignored when empty)
//   flush               : empty the queue; overrides push and pop
//   count               : number of valid entries (0..2)
//   head_valid,
//   head_instr, head_pc : head entry
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_instr,
    input  logic [WIDTH-1:0] push_pc,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_instr,
    output logic [WIDTH-1:0] head_pc
);
    logic [WIDTH-1:0] instr0, pc0, instr1, pc1;
    logic [1:0]       count_q;
    logic             do_pop, do_push;

    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr0  <= '0;
            pc0     <= '0;
            instr1  <= '0;
            pc1     <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        instr0 <= push_instr;
                        pc0    <= push_pc;
                    end else begin
                        instr1 <= push_instr;
                        pc1    <= push_pc;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    instr0  <= instr1;
                    pc0     <= pc1;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new entry lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        instr0 <= push_instr;
                        pc0    <= push_pc;
                    end else begin
                        instr0 <= instr1;
                        pc0    <= pc1;
                        instr1 <= push_instr;
                        pc1    <= push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_instr = instr0;
    assign head_pc    = pc0;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, issues one word read at a time to
// instruction memory, buffers responses in a 2-entry queue and hands them to
// decode over valid/ready. A taken-branch redirect flushes the queue and
// discards any response still in flight.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.master (imem request/response, decode handshake,
//          redirect inputs PCsrc/branch_pc/ImmOp)
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_sum, target;
    logic [WIDTH-1:0] req_pc;
    logic [1:0]       count;
    logic             redirect, issue, push, pop;

    // Redirect target: branch_pc + ImmOp, word aligned, wrapping.
    assign target_sum = bus.branch_pc + bus.ImmOp;
    assign target     = {target_sum[WIDTH-1:2], 2'b00};

    // While a kept request is outstanding no redirect has happened since it was
    // issued, so its address is simply one word behind the current pc.
    assign req_pc = pc_q - WIDTH'(INSTR_BYTES);

    assign redirect = bus.PCsrc && (state_q != BOOT);
    assign issue    = (state_q == RUN) && (count != 2'd2) && !bus.PCsrc;
    assign push     = (state_q == WAIT) && bus.imem_rvalid && !bus.PCsrc;
    assign pop      = bus.instr_valid && bus.instr_ready;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect)
            pc_d = target;
        else if (issue)
            pc_d = pc_q + WIDTH'(INSTR_BYTES);

        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (issue)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid)
                    state_d = RUN;
                else if (bus.PCsrc)
                    state_d = DROP;
            end
            DROP: begin
                if (bus.imem_rvalid)
                    state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    fetch_queue #(
        .WIDTH (WIDTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_instr (bus.imem_rdata),
        .push_pc    (req_pc),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (bus.instr_valid),
        .head_instr (bus.instr),
        .head_pc    (bus.instr_pc)
    );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the reduced RISC-V core. Sits directly upstream of instruction decode (control unit and sign extend): it owns the program counter, issues word reads to instruction memory, and buffers returned instructions in a 2-entry queue. It presents each instruction with its PC to decode over a valid/ready handshake. Taken-branch redirects from decode (PCsrc, ImmOp) flush the queue and discard any in-flight response.

## Interface
Parameters:
- WIDTH, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  read request; accepted by memory in the cycle it is high.
- imem_addr  out  WIDTH  byte address of the request; valid when imem_req=1.
- imem_rvalid  in  1  response strobe, at least 1 cycle after its request.
- imem_rdata  in  WIDTH  instruction word; valid when imem_rvalid=1.
- instr_valid  out  1  queue head valid to decode.
- instr_ready  in  1  decode accepts head.
- instr  out  WIDTH  head instruction.
- instr_pc  out  WIDTH  byte address the head was fetched from.
- PCsrc  in  1  taken-branch redirect, one-cycle pulse.
- branch_pc  in  WIDTH  PC of the redirecting instruction.
- ImmOp  in  WIDTH  sign-extended branch offset.

## Operation
- State registers: pc, FSM state, queue (instr, instr_pc, count 0..2).
- FSM states:
  - BOOT: entered on reset. imem_req=0; PCsrc and imem_rvalid are ignored. Goes to RUN after one cycle.
  - RUN: no request outstanding.
  - WAIT: one request outstanding, response will be kept.
  - DROP: one request outstanding, response will be discarded.
- Issue, in RUN: when count<2 and PCsrc=0, drive imem_req=1 with imem_addr=pc. On the edge, pc<=pc+4 and the FSM goes to WAIT.
- Receive, in WAIT: on imem_rvalid, push {imem_rdata, request address} and go to RUN. There is no new issue in the same cycle.
- Receive, in DROP: on imem_rvalid, discard the data and go to RUN.
- Redirect (PCsrc=1, any state except BOOT):
  - On the edge, pc<=(branch_pc+ImmOp) with bits [1:0] cleared, and the queue is emptied. A pop in that cycle is ignored.
  - Next state: RUN→RUN; WAIT with rvalid=0→DROP; WAIT with rvalid=1→RUN (response discarded); DROP→DROP, or RUN if rvalid=1.
- Pop: instr_valid && instr_ready removes the head. A simultaneous push and pop leaves count unchanged, and order is preserved.
- Overflow is impossible by construction: issue requires count<2, and at most one request is outstanding.
- A response arriving in RUN or BOOT is a protocol violation. It is ignored, and the bench asserts it never occurs.
- Arithmetic: all additions are WIDTH-bit and wrap modulo 2^WIDTH. Misaligned targets are not trapped; bits [1:0] are cleared.

## Timing
- Reset values: pc=RESET_PC, state=BOOT, count=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- imem_req and imem_addr are combinational from state, count, pc and PCsrc. instr_valid, instr and instr_pc are combinational from queue registers only.
- First request is issued in the 2nd cycle after rst deasserts.
- Latency: with a 1-cycle memory, an instruction reaches instr_valid 2 cycles after its request. Peak throughput is 1 instruction per 2 cycles.
- Redirect: the first target request appears in the cycle after PCsrc (RUN) or after the discarded response (DROP).
- Reset asserted mid-operation: the FSM returns to BOOT immediately, and the queue and pc are cleared asynchronously. Instruction memory shares rst, so no stale response follows.

## Structure
- Shared package cpu_pkg holds:
  - fetch_state_t enum {BOOT, RUN, WAIT, DROP}.
  - INSTR_BYTES=4.
  - Default RESET_PC.
- One sub-module, fetch_queue: a 2-entry FIFO of {instr, pc} with push, pop, flush, count and head outputs.
- The top handles the FSM, the pc register and the target adder.

## Test plan
- Reset: rst=1 → imem_req=0, instr_valid=0. After release → cycle 1 imem_req=0, cycle 2 imem_req=1 with imem_addr=0x0.
- Streaming: 1-cycle memory returning 0x00A00093, 0x00100113, …, instr_ready=1 → instr_pc sequence 0x0, 0x4, 0x8, one instruction every 2 cycles, with instr data matching.
- Backpressure: instr_ready=0 → after two fills count=2 and imem_req stays 0. Raise ready → 0x0 then 0x4 pop in order, then fetch resumes at 0x8.
- Redirect in WAIT: branch_pc=0x8, ImmOp=0xFFFFFFF8 with the response one cycle later → state DROP, response discarded, next imem_addr=0x0, instr_valid=0 until the new data arrives.
- Redirect coincident with rvalid: branch_pc=0x10, ImmOp=0x20 → response discarded, state RUN, next cycle imem_addr=0x30.
- Wrap: RESET_PC=0xFFFFFFFC → fetch addresses 0xFFFFFFFC then 0x00000000.
